hwpe_ctrl_seq_mac: RTL and testbench

Parametrised sequential multiply-accumulate unit for HWPE control/address arithmetic. Successor to the single-bit-per-cycle sequential multiplier: adds a configurable radix (BPC multiplier bits per cycle), a signed/unsigned mode, an accumulate mode and a valid/ready-style start handshake. Sits in controller/uloop datapaths where a full-width combinational multiplier is too costly.

---
 rtl/hwpe_ctrl_seq_mac.sv | 197 +++++++++++++++++++
 tb/tb_hwpe_ctrl_seq_mac.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/hwpe_ctrl_seq_mac.sv
// rtl/hwpe_ctrl_seq_mac.sv - radix-2^BPC sequential multiply-accumulate unit
//
// Retires BPC multiplier bits per cycle. An accepted start latches the operands.
// NCYC steps follow, and the result appears on prod_o together with a one-cycle
// valid_o strobe.
//
// Optional feature macro: HWPE_CTRL_SEQ_MAC_SATURATE_EN
//   defined   : accumulation saturates, and overflow_o is a sticky flag
//   undefined : accumulation wraps modulo 2^ACCW, and overflow_o is tied to 0
//
// Ports:
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   clear_i             synchronous abort and accumulator clear (wins over start_i)
//   start_i, ready_o    start request, accepted only while ready_o=1
//   a_i, b_i            multiplier / multiplicand, sampled on an accepted start
//   signed_i            two's-complement operands, sampled on an accepted start
//   accumulate_i        add the product to the accumulator, sampled on an accepted start
//   busy_o, valid_o     running / one-cycle result strobe
//   prod_o              result / accumulator value
//   overflow_o          sticky saturation flag
module hwpe_ctrl_seq_mac #(
  parameter int AW   = 16,
  parameter int BW   = 16,
  parameter int BPC  = 2,
  parameter int ACCW = 40
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clear_i,
  input  logic            start_i,
  output logic            ready_o,
  input  logic [AW-1:0]   a_i,
  input  logic [BW-1:0]   b_i,
  input  logic            signed_i,
  input  logic            accumulate_i,
  output logic            busy_o,
  output logic            valid_o,
  output logic [ACCW-1:0] prod_o,
  output logic            overflow_o
);

  localparam int NCYC = (AW + BPC - 1) / BPC;
  localparam int EAW  = NCYC * BPC;
  localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [EAW-1:0]  a_sh_q, a_sh_d;
  logic [ACCW-1:0] b_sh_q, b_sh_d;
  logic [ACCW-1:0] psum_q, psum_d;
  logic [ACCW-1:0] acc_q, acc_d;
  logic            signed_q, signed_d;
  logic            accum_q, accum_d;

  logic [BPC-1:0]  digit;
  logic            last_step;
  logic            neg_digit;
  logic [ACCW-1:0] pp_pos;
  logic [ACCW-1:0] pp;
  logic [ACCW-1:0] prod_w;
  logic [ACCW-1:0] acc_fin;
  logic            start_acc;

  // One radix digit per step. b_sh_q is pre-shifted, so each partial product
  // already carries its weight. In signed mode the top digit of the
  // sign-extended multiplier has a negative weight: d - 2^BPC when its MSB is set.
  assign digit     = a_sh_q[BPC-1:0];
  assign last_step = (cnt_q == CW'(NCYC - 1));
  assign neg_digit = signed_q & last_step & digit[BPC-1];
  assign pp_pos    = b_sh_q * ACCW'(digit);
  assign pp        = neg_digit ? (pp_pos - (b_sh_q << BPC)) : pp_pos;
  assign prod_w    = psum_q + pp;

`ifdef HWPE_CTRL_SEQ_MAC_SATURATE_EN
  logic [ACCW:0] sum_w;
  logic          sat_hit;
  logic          ovf_q;

  always_comb begin
    sum_w   = {1'b0, acc_q} + {1'b0, prod_w};
    acc_fin = sum_w[ACCW-1:0];
    sat_hit = 1'b0;
    if (!accum_q) begin
      acc_fin = prod_w;
    end else if (signed_q) begin
      // Signed overflow: both addends have the same sign and the sum has the opposite sign.
      if (!acc_q[ACCW-1] && !prod_w[ACCW-1] && sum_w[ACCW-1]) begin
        acc_fin = {1'b0, {(ACCW-1){1'b1}}};
        sat_hit = 1'b1;
      end else if (acc_q[ACCW-1] && prod_w[ACCW-1] && !sum_w[ACCW-1]) begin
        acc_fin = {1'b1, {(ACCW-1){1'b0}}};
        sat_hit = 1'b1;
      end
    end else if (sum_w[ACCW]) begin
      acc_fin = '1;
      sat_hit = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ovf_q <= 1'b0;
    end else if (clear_i) begin
      ovf_q <= 1'b0;
    end else if (state_q == RUN && last_step && sat_hit) begin
      ovf_q <= 1'b1;
    end
  end

  assign overflow_o = ovf_q;
`else
  always_comb begin
    acc_fin = accum_q ? (acc_q + prod_w) : prod_w;
  end

  assign overflow_o = 1'b0;
`endif

  assign start_acc = start_i & (state_q != RUN);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      psum_q   <= '0;
      acc_q    <= '0;
      signed_q <= 1'b0;
      accum_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      psum_q   <= psum_d;
      acc_q    <= acc_d;
      signed_q <= signed_d;
      accum_q  <= accum_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    psum_d   = psum_q;
    acc_d    = acc_q;
    signed_d = signed_q;
    accum_d  = accum_q;

    if (clear_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      acc_d   = '0;
    end else begin
      case (state_q)
        RUN: begin
          a_sh_d = a_sh_q >> BPC;
          b_sh_d = b_sh_q << BPC;
          psum_d = prod_w;
          if (last_step) begin
            // acc_q is written only here, so prod_o never shows a partial sum.
            acc_d   = acc_fin;
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          // IDLE or DONE: both can accept a start. DONE falls back to IDLE after one cycle.
          if (start_acc) begin
            state_d  = RUN;
            cnt_d    = '0;
            psum_d   = '0;
            a_sh_d   = signed_i ? EAW'($signed(a_i)) : EAW'(a_i);
            b_sh_d   = signed_i ? ACCW'($signed(b_i)) : ACCW'(b_i);
            signed_d = signed_i;
            accum_d  = accumulate_i;
          end else begin
            state_d = IDLE;
          end
        end
      endcase
    end
  end

  assign ready_o = (state_q != RUN);
  assign busy_o  = (state_q == RUN);
  assign valid_o = (state_q == DONE);
  assign prod_o  = acc_q;

endmodule

// File: tb/tb_hwpe_ctrl_seq_mac.sv
// tb/tb_hwpe_ctrl_seq_mac.sv - self-checking bench for hwpe_ctrl_seq_mac (AW=BW=8, BPC=2, ACCW=20)
module tb_hwpe_ctrl_seq_mac;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        clear_i;
  logic        start_i;
  logic        ready_o;
  logic [7:0]  a_i;
  logic [7:0]  b_i;
  logic        signed_i;
  logic        accumulate_i;
  logic        busy_o;
  logic        valid_o;
  logic [19:0] prod_o;
  logic        overflow_o;

  int tests = 0;
  int fails = 0;

  logic [19:0] acc_m = '0;
  bit          ovf_m = 1'b0;

  always #5 clk_i = ~clk_i;

  hwpe_ctrl_seq_mac #(.AW(8), .BW(8), .BPC(2), .ACCW(20)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .clear_i      (clear_i),
    .start_i      (start_i),
    .ready_o      (ready_o),
    .a_i          (a_i),
    .b_i          (b_i),
    .signed_i     (signed_i),
    .accumulate_i (accumulate_i),
    .busy_o       (busy_o),
    .valid_o      (valid_o),
    .prod_o       (prod_o),
    .overflow_o   (overflow_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the operand values.
  task automatic model_op(input logic [7:0] a, input logic [7:0] b, input bit s, input bit ac);
    longint pa, pb, pr, sum;
    pa = s ? longint'($signed(a)) : longint'(a);
    pb = s ? longint'($signed(b)) : longint'(b);
    pr = pa * pb;
    if (!ac) begin
      sum = pr;
    end else begin
`ifdef HWPE_CTRL_SEQ_MAC_SATURATE_EN
      if (s) begin
        sum = longint'($signed(acc_m)) + pr;
        if (sum > 524287) begin sum = 524287; ovf_m = 1'b1; end
        else if (sum < -524288) begin sum = -524288; ovf_m = 1'b1; end
      end else begin
        sum = longint'(acc_m) + pr;
        if (sum > 1048575) begin sum = 1048575; ovf_m = 1'b1; end
      end
`else
      sum = longint'(acc_m) + pr;
`endif
    end
    acc_m = sum[19:0];
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input bit s, input bit ac,
                        input bit hold_start);
    logic [19:0] old_acc;
    old_acc = acc_m;
    @(negedge clk_i);
    start_i = 1'b1; a_i = a; b_i = b; signed_i = s; accumulate_i = ac;
    @(posedge clk_i); #1;
    if (!hold_start) start_i = 1'b0;
    chk("busy_after_start", 32'(busy_o), 32'd1);
    chk("ready_in_run", 32'(ready_o), 32'd0);
    model_op(a, b, s, ac);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk_i); #1;
      if (k < 4) begin
        chk("no_valid_in_run", 32'(valid_o), 32'd0);
        chk("prod_hidden_in_run", 32'(prod_o), 32'(old_acc));
      end
    end
    chk("valid_done", 32'(valid_o), 32'd1);
    chk("ready_done", 32'(ready_o), 32'd1);
    chk("prod", 32'(prod_o), 32'(acc_m));
    chk("overflow", 32'(overflow_o), 32'(ovf_m));
    start_i = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk_i);
    clear_i = 1'b1;
    @(posedge clk_i); #1;
    clear_i = 1'b0;
    acc_m = '0;
    ovf_m = 1'b0;
    chk("clear_prod", 32'(prod_o), 32'd0);
    chk("clear_ovf", 32'(overflow_o), 32'd0);
  endtask

  initial begin
    rst_ni = 1'b0; clear_i = 1'b0; start_i = 1'b0;
    a_i = '0; b_i = '0; signed_i = 1'b0; accumulate_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_ready", 32'(ready_o), 32'd1);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_prod", 32'(prod_o), 32'd0);
    chk("rst_ovf", 32'(overflow_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Unsigned full-scale product.
    run_op(8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0);
    chk("ff_x_ff", 32'(prod_o), 32'h0FE01);
    @(posedge clk_i); #1;
    chk("done_to_idle_valid", 32'(valid_o), 32'd0);

    // Signed versus unsigned interpretation of the same bits.
    run_op(8'h80, 8'h7F, 1'b1, 1'b0, 1'b0);
    chk("signed_80_7f", 32'(prod_o), 32'hFC080);
    run_op(8'h80, 8'h7F, 1'b0, 1'b0, 1'b0);
    chk("unsigned_80_7f", 32'(prod_o), 32'h03F80);

    // Back-to-back accumulation: each start is issued in the DONE cycle.
    do_clear();
    run_op(8'd3, 8'd5, 1'b0, 1'b1, 1'b0);
    chk("acc_15", 32'(prod_o), 32'd15);
    run_op(8'd3, 8'd5, 1'b0, 1'b1, 1'b0);
    chk("acc_30", 32'(prod_o), 32'd30);
    run_op(8'd3, 8'd5, 1'b0, 1'b1, 1'b0);
    chk("acc_45", 32'(prod_o), 32'd45);
    @(posedge clk_i); #1;

    // A start held high through RUN is ignored.
    run_op(8'd7, 8'd9, 1'b0, 1'b0, 1'b1);
    chk("held_start_prod", 32'(prod_o), 32'd63);
    @(posedge clk_i); #1;
    chk("held_start_single_valid", 32'(valid_o), 32'd0);
    chk("held_start_idle_ready", 32'(ready_o), 32'd1);

    // A clear after e2 aborts the operation.
    @(negedge clk_i);
    start_i = 1'b1; a_i = 8'd11; b_i = 8'd13; signed_i = 1'b0; accumulate_i = 1'b0;
    @(posedge clk_i); #1; start_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1; clear_i = 1'b1;
    @(posedge clk_i); #1; clear_i = 1'b0;
    acc_m = '0; ovf_m = 1'b0;
    chk("abort_valid", 32'(valid_o), 32'd0);
    chk("abort_prod", 32'(prod_o), 32'd0);
    chk("abort_ready", 32'(ready_o), 32'd1);
    chk("abort_busy", 32'(busy_o), 32'd0);
    repeat (3) begin
      @(posedge clk_i); #1;
      chk("abort_no_late_valid", 32'(valid_o), 32'd0);
    end

    // Unsigned accumulation past full scale.
    do_clear();
    for (int i = 0; i < 17; i++) run_op(8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0);
`ifdef HWPE_CTRL_SEQ_MAC_SATURATE_EN
    chk("usat_prod", 32'(prod_o), 32'hFFFFF);
    chk("usat_ovf", 32'(overflow_o), 32'd1);
    @(posedge clk_i); #1;
    chk("usat_ovf_sticky", 32'(overflow_o), 32'd1);
`else
    chk("uwrap_prod", 32'(prod_o), 32'h0DE11);
    chk("uwrap_ovf", 32'(overflow_o), 32'd0);
`endif
    do_clear();

    // Signed accumulation past full scale.
    for (int i = 0; i < 33; i++) run_op(8'h80, 8'h80, 1'b1, 1'b1, 1'b0);
`ifdef HWPE_CTRL_SEQ_MAC_SATURATE_EN
    chk("ssat_prod", 32'(prod_o), 32'h7FFFF);
    chk("ssat_ovf", 32'(overflow_o), 32'd1);
`else
    chk("swrap_prod", 32'(prod_o), 32'h84000);
`endif
    do_clear();

    // Randomized operations checked against the model.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(7) == 0) do_clear();
      if ($urandom_range(3) == 0) begin
        @(posedge clk_i); #1;
      end
      run_op(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    end

    // A reset pulse in the middle of RUN clears the outputs at once.
    run_op(8'd200, 8'd100, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i);
    start_i = 1'b1; a_i = 8'd21; b_i = 8'd3; signed_i = 1'b0; accumulate_i = 1'b1;
    @(posedge clk_i); #1; start_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1; rst_ni = 1'b0;
    #1;
    chk("midrst_prod", 32'(prod_o), 32'd0);
    chk("midrst_busy", 32'(busy_o), 32'd0);
    chk("midrst_valid", 32'(valid_o), 32'd0);
    chk("midrst_ovf", 32'(overflow_o), 32'd0);
    chk("midrst_ready", 32'(ready_o), 32'd1);
    @(negedge clk_i);
    rst_ni = 1'b1;
    acc_m = '0; ovf_m = 1'b0;
    repeat (4) begin
      @(posedge clk_i); #1;
      chk("midrst_no_valid", 32'(valid_o), 32'd0);
    end
    run_op(8'd21, 8'd3, 1'b0, 1'b1, 1'b0);
    chk("post_rst_acc", 32'(prod_o), 32'd63);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
